// File: rtl/transfer_link_scheduler_pkg.sv
// Shared definitions for the outbound transfer link scheduler:
// FSM state encodings and serial line constants.
package transfer_link_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } state_e;

    localparam logic START_BIT = 1'b1;
    localparam logic IDLE_LINE = 1'b0;
    localparam bit   MSB_FIRST = 1'b1;

endpackage

// File: rtl/transfer_link_scheduler_arbiter.sv
// Two-input round-robin arbiter: combinational one-hot grant,
// registered pointer naming the scanner that wins the next tie.
// Ports: clk, rst (async active-low), req_i[1:0], en_i, gnt_o[1:0], rr_ptr_o
module transfer_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       rr_ptr_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // After any grant the pointer names the other scanner; for a tie
    // this is exactly a toggle.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i && (req_i != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign rr_ptr_o = ptr_q;

endmodule

// File: rtl/transfer_link_scheduler.sv
// Shares one outbound serial link between two scanners: arbitrates,
// handshakes with the remote center, then sends start bit + payload.
// Ports: clk, rst (async active-low), scanReq[1:0], scanData0/1,
//   readyForTransferIn, readyForTransferOut, dataOut, grant[1:0],
//   ack[1:0], nack[1:0], bitCounter, busy
module transfer_link_scheduler
    import transfer_link_scheduler_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                scanReq,
    input  logic [DATA_W-1:0]         scanData0,
    input  logic [DATA_W-1:0]         scanData1,
    input  logic                      readyForTransferIn,
    output logic                      readyForTransferOut,
    output logic                      dataOut,
    output logic [1:0]                grant,
    output logic [1:0]                ack,
    output logic [1:0]                nack,
    output logic [$clog2(DATA_W)-1:0] bitCounter,
    output logic                      busy
);

    localparam int BW = $clog2(DATA_W);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BC_TOP = BW'(DATA_W - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [BW-1:0]     bc_q, bc_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic [1:0] arb_gnt;
    logic       arb_en;
    logic       rr_ptr;
    logic [1:0] owner;
    logic       in_frame;
    logic [BW-1:0] bit_idx;

    transfer_rr_arbiter u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (scanReq),
        .en_i     (arb_en),
        .gnt_o    (arb_gnt),
        .rr_ptr_o (rr_ptr)
    );

    // The pointer always names the non-owner once a grant is taken,
    // so the owner needs no register of its own.
    assign owner = rr_ptr ? 2'b01 : 2'b10;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        bc_d    = bc_q;
        tmo_d   = tmo_q;
        arb_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (scanReq != 2'b00) begin
                    arb_en  = 1'b1;
                    buf_d   = arb_gnt[1] ? scanData1 : scanData0;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (readyForTransferIn) begin
                    bc_d    = BC_TOP;
                    state_d = S_START;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_START: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (bc_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    bc_d = bc_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            bc_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            bc_q    <= bc_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bit_idx = MSB_FIRST ? bc_q : (BC_TOP - bc_q);

    always_comb begin
        in_frame = (state_q == S_WAIT) || (state_q == S_START) ||
                   (state_q == S_SHIFT);
        dataOut  = IDLE_LINE;
        unique case (state_q)
            S_START: dataOut = START_BIT;
            S_SHIFT: dataOut = buf_q[bit_idx];
            default: dataOut = IDLE_LINE;
        endcase
    end

    assign readyForTransferOut = in_frame;
    assign grant      = in_frame ? owner : 2'b00;
    assign ack        = (state_q == S_DONE) ? owner : 2'b00;
    assign nack       = (state_q == S_ABORT) ? owner : 2'b00;
    assign bitCounter = bc_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_transfer_link_scheduler.sv
// Self-checking bench for transfer_link_scheduler: frame-level model
// compared every cycle, plus directed scenarios with literal checks.
module tb_transfer_link_scheduler;

    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    scanReq = 2'b00;
    logic [DW-1:0] scanData0 = '0;
    logic [DW-1:0] scanData1 = '0;
    logic          readyForTransferIn = 1'b0;
    logic          readyForTransferOut;
    logic          dataOut;
    logic [1:0]    grant;
    logic [1:0]    ack;
    logic [1:0]    nack;
    logic [2:0]    bitCounter;
    logic          busy;

    int errors = 0;
    int checks = 0;

    transfer_link_scheduler #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .scanReq             (scanReq),
        .scanData0           (scanData0),
        .scanData1           (scanData1),
        .readyForTransferIn  (readyForTransferIn),
        .readyForTransferOut (readyForTransferOut),
        .dataOut             (dataOut),
        .grant               (grant),
        .ack                 (ack),
        .nack                (nack),
        .bitCounter          (bitCounter),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Frame-level model: owner, WAIT cycles spent, cycles since start bit.
    int          m_own  = -1;
    int          m_ptr  = 0;
    int          m_wait = 0;
    int          m_k    = -1;
    int          m_ack  = -1;
    int          m_nack = -1;
    logic [DW-1:0] m_buf = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_own = -1; m_ptr = 0; m_wait = 0;
            m_k = -1; m_ack = -1; m_nack = -1; m_buf = '0;
        end else if (m_ack >= 0 || m_nack >= 0) begin
            m_ack = -1;
            m_nack = -1;
        end else if (m_own < 0) begin
            if (scanReq != 2'b00) begin
                if (scanReq == 2'b01)      m_own = 0;
                else if (scanReq == 2'b10) m_own = 1;
                else                       m_own = m_ptr;
                m_ptr  = 1 - m_own;
                m_buf  = (m_own == 1) ? scanData1 : scanData0;
                m_wait = 0;
                m_k    = -1;
            end
        end else if (m_k < 0) begin
            if (readyForTransferIn) begin
                m_k = 0;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_nack = m_own;
                    m_own  = -1;
                end
            end
        end else begin
            m_k++;
            if (m_k == DW + 1) begin
                m_ack = m_own;
                m_own = -1;
            end
        end
    end

    always @(negedge clk) begin
        int e_gnt, e_d, e_bc, e_ack, e_nack, e_busy, e_rfo;
        e_gnt  = (m_own >= 0) ? (1 << m_own) : 0;
        e_rfo  = (m_own >= 0) ? 1 : 0;
        e_ack  = (m_ack >= 0) ? (1 << m_ack) : 0;
        e_nack = (m_nack >= 0) ? (1 << m_nack) : 0;
        e_busy = (m_own >= 0 || m_ack >= 0 || m_nack >= 0) ? 1 : 0;
        e_d  = 0;
        e_bc = 0;
        if (m_own >= 0 && m_k == 0) begin
            e_d  = 1;
            e_bc = DW - 1;
        end else if (m_own >= 0 && m_k >= 1 && m_k <= DW) begin
            e_d  = int'(m_buf[DW - m_k]);
            e_bc = DW - m_k;
        end
        chk("grant", int'(grant), e_gnt);
        chk("rfo", int'(readyForTransferOut), e_rfo);
        chk("dataOut", int'(dataOut), e_d);
        chk("bitCounter", int'(bitCounter), e_bc);
        chk("ack", int'(ack), e_ack);
        chk("nack", int'(nack), e_nack);
        chk("busy", int'(busy), e_busy);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input string name, input int lim,
                            output logic [1:0] a);
        a = 2'b00;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                a = ack;
                break;
            end
        end
        if (a == 2'b00) chk({name, "_ack_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input int lim);
        int ok;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        logic [1:0] a;
        logic [8:0] bits;
        int gcnt, ones, found, acks;
        int glist[$];
        logic [1:0] pg;

        // 1: reset held across a clock with both requests
        rst = 1'b0;
        scanReq = 2'b11;
        scanData0 = 8'h3C;
        scanData1 = 8'h77;
        cyc(2);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dataOut", int'(dataOut), 0);
        chk("rst_acknack", int'({ack, nack}), 0);
        rst = 1'b1;
        cyc(1);
        chk("first_tie_grant", int'(grant), 1);
        scanReq = 2'b00;
        readyForTransferIn = 1'b1;
        wait_ack("t1", 40, a);
        chk("t1_ack", int'(a), 1);
        wait_idle(10);

        // 2: single frame, ready after two WAIT cycles
        readyForTransferIn = 1'b0;
        scanReq = 2'b01;
        scanData0 = 8'hA5;
        cyc(1);
        chk("t2_grant", int'(grant), 1);
        scanReq = 2'b00;
        gcnt = (grant != 0) ? 1 : 0;
        cyc(1);
        if (grant != 0) gcnt++;
        readyForTransferIn = 1'b1;
        bits = '0;
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            bits = {bits[7:0], dataOut};
            if (grant != 0) gcnt++;
        end
        cyc(1);
        chk("t2_bits", int'(bits), 9'b1_1010_0101);
        chk("t2_ack", int'(ack), 1);
        chk("t2_grant_cycles", gcnt, 11);
        wait_idle(10);

        // 4: timeout on scanner 1
        readyForTransferIn = 1'b0;
        scanReq = 2'b10;
        scanData1 = 8'hFF;
        cyc(1);
        chk("t4_grant", int'(grant), 2);
        scanReq = 2'b00;
        ones = 0;
        found = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (dataOut) ones++;
            if (nack != 2'b00) begin
                chk("t4_nack", int'(nack), 2);
                found = i;
                break;
            end
        end
        chk("t4_nack_cycle", found, TO);
        chk("t4_no_data", ones, 0);
        cyc(1);
        chk("t4_busy_drop", int'(busy), 0);

        // 3: contention with remote always ready
        readyForTransferIn = 1'b1;
        scanData0 = 8'h0F;
        scanData1 = 8'hF0;
        scanReq = 2'b11;
        pg = 2'b00;
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (grant != 2'b00 && pg == 2'b00) glist.push_back(int'(grant));
            pg = grant;
            if (ack != 2'b00) begin
                acks++;
                if (acks == 3) begin
                    scanReq = 2'b00;
                    break;
                end
            end
        end
        chk("t3_acks", acks, 3);
        chk("t3_frames", glist.size(), 3);
        if (glist.size() == 3) begin
            chk("t3_g0", glist[0], 1);
            chk("t3_g1", glist[1], 2);
            chk("t3_g2", glist[2], 1);
        end
        wait_idle(10);

        // 5: remote drops ready after bit 5
        readyForTransferIn = 1'b1;
        scanReq = 2'b01;
        scanData0 = 8'h5A;
        cyc(1);
        scanReq = 2'b00;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (bitCounter == 3'd5) begin
                found = 1;
                break;
            end
        end
        chk("t5_reach_bit5", found, 1);
        readyForTransferIn = 1'b0;
        wait_ack("t5", 20, a);
        chk("t5_ack", int'(a), 1);
        wait_idle(10);

        // 6: reset during SHIFT bit 3
        readyForTransferIn = 1'b1;
        scanReq = 2'b10;
        scanData1 = 8'hC3;
        cyc(1);
        scanReq = 2'b00;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (bitCounter == 3'd3) begin
                found = 1;
                break;
            end
        end
        chk("t6_reach_bit3", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_dataOut", int'(dataOut), 0);
        chk("t6_rst_grant", int'(grant), 0);
        chk("t6_rst_busy", int'(busy), 0);
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            if (ack != 2'b00 || nack != 2'b00) acks++;
        end
        chk("t6_no_pulse", acks, 0);
        rst = 1'b1;
        readyForTransferIn = 1'b0;
        scanReq = 2'b10;
        scanData1 = 8'h81;
        cyc(1);
        chk("t6_regrant", int'(grant), 2);
        scanReq = 2'b00;
        readyForTransferIn = 1'b1;
        cyc(1);
        chk("t6_start_bit", int'(dataOut), 1);
        chk("t6_start_bc", int'(bitCounter), 7);
        wait_ack("t6", 20, a);
        chk("t6_ack", int'(a), 2);
        wait_idle(10);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
